// File: rtl/mlaccel_pkg.sv
// mlaccel_pkg
// Shared definitions for the ML accelerator command sequencer:
//   - instruction field layout (maddr [31:15], caddr [14:6], opcode [5:0])
//   - opcode constants for the opcodes the sequencer interprets itself
//   - sequencer FSM state encoding
package mlaccel_pkg;

  localparam int INSN_W   = 32;
  localparam int MADDR_W  = 17;
  localparam int CADDR_W  = 9;
  localparam int OPCODE_W = 6;

  // Field positions follow from declaration order: maddr occupies the top bits.
  typedef struct packed {
    logic [MADDR_W-1:0]  maddr;   // [31:15]
    logic [CADDR_W-1:0]  caddr;   // [14:6]
    logic [OPCODE_W-1:0] opcode;  // [5:0]
  } insn_t;

  localparam logic [OPCODE_W-1:0] OP_NOP    = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_SYNC   = 6'd1;
  localparam logic [OPCODE_W-1:0] OP_REPEAT = 6'd2;

  // Cycles the sequencer holds in SYNC before it even looks at compute_busy.
  localparam logic [1:0] SYNC_HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_REP_ARM = 2'd1,
    ST_REP_RUN = 2'd2,
    ST_SYNC    = 2'd3
  } state_t;

endpackage

// File: rtl/mlaccel_cmdseq_fifo.sv
// mlaccel_cmdseq_fifo
// Synchronous command FIFO with a level counter. Read data is the head entry,
// valid whenever empty is low; pop advances to the next entry.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-low reset
//   push, wr_data  write request and data (ignored while full)
//   pop, rd_data   read advance and head entry (pop ignored while empty)
//   full, empty    level flags
module mlaccel_cmdseq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == FULL_LEVEL);
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr_q];

  // NOTE: every signal this block drives gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so the pointers wrap on their own.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;  // idle, or push and pop cancel out
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and the
  // level counter alone decide which entries hold valid data.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mlaccel_cmdseq.sv
// mlaccel_cmdseq
// Command sequencer: buffers host commands in a FIFO and issues them to the
// compute stage through a registered valid/ready output slot. Nop and Sync
// are consumed locally; Sync waits for the compute pipeline to drain. With
// MLACCEL_CMDSEQ_REPEAT_EN defined, Repeat expands the following command into
// count+1 issues with strided maddr and incrementing caddr; otherwise Repeat
// is treated as Nop.
// Ports:
//   clock, reset             rising-edge clock, synchronous active-low reset
//   in_valid/in_ready/in_insn   host command push interface
//   cmd_valid/cmd_ready/cmd_insn  registered command output to compute stage
//   compute_busy             compute pipeline occupied (gates Sync release)
//   busy                     any command still buffered, pending or expanding
module mlaccel_cmdseq
  import mlaccel_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [INSN_W-1:0] cmd_insn,
  input  logic              compute_busy,
  output logic              busy
);

  logic              fifo_full, fifo_empty, fifo_pop;
  insn_t             fifo_rd;
  logic              slot_free;

  state_t            state_q, state_d;
  logic [1:0]        hold_q, hold_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [INSN_W-1:0] cmd_insn_q, cmd_insn_d;

`ifdef MLACCEL_CMDSEQ_REPEAT_EN
  logic [CADDR_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [MADDR_W-1:0] rep_stride_q, rep_stride_d;
  insn_t              rep_insn_q, rep_insn_d;
  insn_t              rep_next;

  // Next command in a repeat burst: maddr and caddr both wrap at field width.
  assign rep_next.maddr  = rep_insn_q.maddr + rep_stride_q;
  assign rep_next.caddr  = rep_insn_q.caddr + 1'b1;
  assign rep_next.opcode = rep_insn_q.opcode;
`endif

  // in_ready is forced low while reset is held, independent of the level.
  assign in_ready  = reset && !fifo_full;
  assign slot_free = !cmd_valid_q || cmd_ready;
  assign cmd_valid = cmd_valid_q;
  assign cmd_insn  = cmd_insn_q;
  assign busy      = !fifo_empty || cmd_valid_q || (state_q != ST_FETCH);

  mlaccel_cmdseq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSN_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (in_valid && in_ready),
    .wr_data (in_insn),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cmd_valid_d = cmd_valid_q && !cmd_ready;  // a handshake empties the slot
    cmd_insn_d  = cmd_insn_q;
    fifo_pop    = 1'b0;
`ifdef MLACCEL_CMDSEQ_REPEAT_EN
    rep_cnt_d    = rep_cnt_q;
    rep_stride_d = rep_stride_q;
    rep_insn_d   = rep_insn_q;
`endif

    case (state_q)
      // FETCH and REP_ARM decode entries identically; they differ only in
      // what happens to an ordinary command (issue vs. start a burst).
      ST_FETCH, ST_REP_ARM: begin
        if (!fifo_empty && slot_free) begin
          fifo_pop = 1'b1;
          case (fifo_rd.opcode)
`ifdef MLACCEL_CMDSEQ_REPEAT_EN
            OP_NOP: begin
              // consumed; an armed repeat stays armed
            end
            OP_REPEAT: begin
              // A Repeat while armed simply replaces the pending one.
              rep_cnt_d    = fifo_rd.caddr;
              rep_stride_d = fifo_rd.maddr;
              state_d      = ST_REP_ARM;
            end
`else
            OP_NOP, OP_REPEAT: begin
              // consumed, nothing issued
            end
`endif
            OP_SYNC: begin
              hold_d  = SYNC_HOLD;
              state_d = ST_SYNC;
            end
            default: begin
              cmd_valid_d = 1'b1;
              cmd_insn_d  = fifo_rd;
`ifdef MLACCEL_CMDSEQ_REPEAT_EN
              if (state_q == ST_REP_ARM) begin
                rep_insn_d = fifo_rd;
                state_d    = (rep_cnt_q == '0) ? ST_FETCH : ST_REP_RUN;
              end
`endif
            end
          endcase
        end
      end

`ifdef MLACCEL_CMDSEQ_REPEAT_EN
      ST_REP_RUN: begin
        if (slot_free) begin
          cmd_valid_d = 1'b1;
          cmd_insn_d  = rep_next;
          rep_insn_d  = rep_next;
          rep_cnt_d   = rep_cnt_q - 1'b1;
          if (rep_cnt_q == 9'd1) state_d = ST_FETCH;
        end
      end
`endif

      ST_SYNC: begin
        // Minimum hold first, then wait for both the output slot and the
        // compute pipeline to be idle.
        if (hold_q != 2'd0) begin
          hold_d = hold_q - 1'b1;
        end else if (!cmd_valid_q && !compute_busy) begin
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      hold_q       <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_insn_q   <= '0;
`ifdef MLACCEL_CMDSEQ_REPEAT_EN
      rep_cnt_q    <= '0;
      rep_stride_q <= '0;
      rep_insn_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_insn_q   <= cmd_insn_d;
`ifdef MLACCEL_CMDSEQ_REPEAT_EN
      rep_cnt_q    <= rep_cnt_d;
      rep_stride_q <= rep_stride_d;
      rep_insn_q   <= rep_insn_d;
`endif
    end
  end

endmodule
